// File: rtl/box_drawer_if.sv
// rtl/box_drawer_if.sv - request/status and memory write port bundle for box_drawer
interface box_drawer_if;
    logic        start;
    logic        done;
    logic        err;
    logic [10:0] xMin;
    logic [10:0] xMax;
    logic [10:0] yMin;
    logic [10:0] yMax;
    logic [23:0] addr;
    logic [15:0] wrdata;
    logic        wren;
    logic        wrready;

    modport master (
        output start, xMin, xMax, yMin, yMax, wrready,
        input  done, err, addr, wrdata, wren
    );

    modport slave (
        input  start, xMin, xMax, yMin, yMax, wrready,
        output done, err, addr, wrdata, wren
    );
endinterface

// File: rtl/box_drawer.sv
// rtl/box_drawer.sv - writes a solid-colour box outline into the column-major RGB buffer
// Optional feature macro BOX_DRAWER_FILL_EN: write every pixel of the rectangle instead.
module box_drawer #(
    parameter int          WIDTH    = 100,
    parameter int          HEIGHT   = 100,
    parameter logic [15:0] COLOUR_R = 16'd255,
    parameter logic [15:0] COLOUR_G = 16'd0,
    parameter logic [15:0] COLOUR_B = 16'd0
) (
    input  logic         clk,
    input  logic         rst,
    box_drawer_if.slave  bus
);
    localparam logic [10:0] X_LAST     = 11'(WIDTH - 1);
    localparam logic [10:0] Y_LAST     = 11'(HEIGHT * 3 - 3);
    localparam logic [23:0] COL_STRIDE = 24'(HEIGHT * 3);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FINISHED} state_t;

    state_t      state_q;
    logic [10:0] x_q, y_q;
    logic [1:0]  ch_q;
    logic [10:0] xmin_q, xmax_q, ymin_q, ymax_q;
    logic        err_q;

    logic        box_ok;
    logic        full_col;
    logic        col_end;
    logic        last_px;
    logic [10:0] x_d, y_d;

    assign box_ok = (bus.xMin <= bus.xMax) && (bus.xMax <= X_LAST) &&
                    (bus.yMin <= bus.yMax) && (bus.yMax <= Y_LAST) &&
                    ((bus.yMin % 11'd3) == 11'd0) && ((bus.yMax % 11'd3) == 11'd0);

`ifdef BOX_DRAWER_FILL_EN
    assign full_col = 1'b1;
`else
    // Only the two edge columns are drawn top to bottom; interior columns get their end pixels.
    assign full_col = (x_q == xmin_q) || (x_q == xmax_q);
`endif

    always_comb begin
        col_end = (y_q == ymax_q);
        last_px = col_end && (x_q == xmax_q);
        x_d     = x_q;
        y_d     = y_q;
        if (col_end) begin
            x_d = x_q + 11'd1;
            y_d = ymin_q;
        end else if (full_col) begin
            y_d = y_q + 11'd3;
        end else begin
            y_d = ymax_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            ch_q    <= '0;
            xmin_q  <= '0;
            xmax_q  <= '0;
            ymin_q  <= '0;
            ymax_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_FINISHED: begin
                    if (bus.start) begin
                        xmin_q <= bus.xMin;
                        xmax_q <= bus.xMax;
                        ymin_q <= bus.yMin;
                        ymax_q <= bus.yMax;
                        err_q  <= !box_ok;
                        if (box_ok) begin
                            x_q     <= bus.xMin;
                            y_q     <= bus.yMin;
                            ch_q    <= 2'd0;
                            state_q <= S_WRITE;
                        end else begin
                            state_q <= S_FINISHED;
                        end
                    end
                end
                S_WRITE: begin
                    if (bus.wrready) begin
                        if (ch_q == 2'd2) begin
                            ch_q <= 2'd0;
                            if (last_px) begin
                                state_q <= S_FINISHED;
                            end else begin
                                x_q <= x_d;
                                y_q <= y_d;
                            end
                        end else begin
                            ch_q <= ch_q + 2'd1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.wren   = (state_q == S_WRITE);
    assign bus.done   = (state_q == S_FINISHED);
    assign bus.err    = err_q;
    assign bus.addr   = 24'(x_q) * COL_STRIDE + 24'(y_q) + 24'(ch_q);
    assign bus.wrdata = (ch_q == 2'd0) ? COLOUR_R :
                        (ch_q == 2'd1) ? COLOUR_G : COLOUR_B;
endmodule

// File: tb/tb_box_drawer.sv
// tb/tb_box_drawer.sv - randomized self-checking bench for box_drawer against a perimeter model
module tb_box_drawer;
    localparam int W = 100;
    localparam int H = 100;
    localparam int STRIDE = H * 3;
    localparam logic [15:0] CR = 16'd255;
    localparam logic [15:0] CG = 16'd0;
    localparam logic [15:0] CB = 16'd0;

    typedef struct {
        logic [23:0] a;
        logic [15:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    box_drawer_if bus();

    box_drawer #(
        .WIDTH(W), .HEIGHT(H), .COLOUR_R(CR), .COLOUR_G(CG), .COLOUR_B(CB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int  n_checks = 0;
    int  n_pass   = 0;
    bit  rand_ready = 1'b0;
    wr_t exp_q[$];
    wr_t act_q[$];
    logic        stall_prev = 1'b0;
    logic [40:0] held;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic bit is_valid(input int xmin, input int xmax, input int ymin, input int ymax);
        return xmin <= xmax && xmax <= W - 1 && ymin <= ymax && ymax <= 3 * H - 3 &&
               ymin % 3 == 0 && ymax % 3 == 0;
    endfunction

    // Reference: every pixel of the rectangle that lies on its perimeter (or all, when filling).
    task automatic build_expected(input int xmin, input int xmax, input int ymin, input int ymax);
        bit fill;
        wr_t w;
`ifdef BOX_DRAWER_FILL_EN
        fill = 1'b1;
`else
        fill = 1'b0;
`endif
        exp_q.delete();
        if (!is_valid(xmin, xmax, ymin, ymax)) return;
        for (int x = xmin; x <= xmax; x++) begin
            for (int y = ymin; y <= ymax; y += 3) begin
                if (fill || x == xmin || x == xmax || y == ymin || y == ymax) begin
                    w.a = 24'(x * STRIDE + y);     w.d = CR; exp_q.push_back(w);
                    w.a = 24'(x * STRIDE + y + 1); w.d = CG; exp_q.push_back(w);
                    w.a = 24'(x * STRIDE + y + 2); w.d = CB; exp_q.push_back(w);
                end
            end
        end
    endtask

    initial begin
        bus.wrready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.wrready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            if (stall_prev) check("stall_hold", {bus.wren, bus.addr, bus.wrdata}, held);
            if (!rst && bus.wren && bus.wrready) begin
                w.a = bus.addr;
                w.d = bus.wrdata;
                act_q.push_back(w);
            end
            stall_prev = !rst && bus.wren && !bus.wrready;
            held = {bus.wren, bus.addr, bus.wrdata};
        end
    end

    task automatic run_box(input int xmin, input int xmax, input int ymin, input int ymax,
                           input bit rnd, input string tag);
        int k;
        int n;
        build_expected(xmin, xmax, ymin, ymax);
        act_q.delete();
        rand_ready = rnd;
        @(posedge clk);
        #1;
        bus.xMin = 11'(xmin);
        bus.xMax = 11'(xmax);
        bus.yMin = 11'(ymin);
        bus.yMax = 11'(ymax);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        k = 1;
        while (!bus.done && k < 5000) begin
            @(posedge clk);
            #1;
            k++;
        end
        rand_ready = 1'b0;
        check({tag, "_done"}, bus.done, 1);
        check({tag, "_err"}, bus.err, !is_valid(xmin, xmax, ymin, ymax));
        if (!rnd) check({tag, "_latency"}, k, exp_q.size() + 1);
        check({tag, "_nwrites"}, act_q.size(), exp_q.size());
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_addr"}, act_q[i].a, exp_q[i].a);
            check({tag, "_data"}, act_q[i].d, exp_q[i].d);
        end
    endtask

    initial begin
        int k;
        int hits;
        int xmin, xmax, ymin, ymax;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.xMin = '0;
        bus.xMax = '0;
        bus.yMin = '0;
        bus.yMax = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_wren", bus.wren, 0);
        check("rst_addr", bus.addr, 0);
        check("rst_wrdata", bus.wrdata, CR);
        rst = 1'b0;

        run_box(2, 4, 3, 9, 1'b0, "box1");
        if (act_q.size() >= 3) begin
            check("box1_first_addr0", act_q[0].a, 603);
            check("box1_first_addr1", act_q[1].a, 604);
            check("box1_first_addr2", act_q[2].a, 605);
            check("box1_first_data0", act_q[0].d, 255);
            check("box1_first_data1", act_q[1].d, 0);
            check("box1_first_data2", act_q[2].d, 0);
        end
        hits = 0;
        foreach (act_q[i]) if (act_q[i].a >= 906 && act_q[i].a <= 908) hits++;
`ifdef BOX_DRAWER_FILL_EN
        check("box1_centre_hits", hits, 3);
`else
        check("box1_centre_hits", hits, 0);
`endif

        run_box(99, 0, 297, 0, 1'b0, "empty");
        run_box(0, 0, 0, 0, 1'b0, "pixel");
        run_box(2, 4, 3, 9, 1'b1, "box1_stall");

        // Reset mid-draw, then redraw from scratch.
        build_expected(2, 4, 3, 9);
        act_q.delete();
        @(posedge clk);
        #1;
        bus.xMin = 11'd2; bus.xMax = 11'd4; bus.yMin = 11'd3; bus.yMax = 11'd9;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        k = 0;
        while (act_q.size() < 5 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("mid_rst_reached5", act_q.size(), 5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_wren", bus.wren, 0);
        check("mid_rst_done", bus.done, 0);
        rst = 1'b0;
        run_box(2, 4, 3, 9, 1'b0, "redraw");

        run_box(97, 99, 291, 297, 1'b0, "corner");

        for (int it = 0; it < 14; it++) begin
            xmin = $urandom_range(0, 95);
            xmax = xmin + $urandom_range(0, 4);
            ymin = 3 * $urandom_range(0, 95);
            ymax = ymin + 3 * $urandom_range(0, 4);
            if (it % 3 == 2) begin
                case ($urandom_range(0, 3))
                    0: begin xmax = xmin; xmin = xmin + 1 + $urandom_range(0, 3); end
                    1: ymin = ymin + 1 + $urandom_range(0, 1);
                    2: xmax = W + $urandom_range(0, 20);
                    default: ymax = 3 * H + $urandom_range(0, 9);
                endcase
            end
            run_box(xmin, xmax, ymin, ymax, 1'($urandom_range(0, 1)), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
